rr_arb4_ctrl: RTL and testbench
===============================

# rr_arb4_ctrl

Four-requester round-robin arbiter that sequences exclusive access to one shared resource. A registered 2-bit owner index is decoded into a one-hot grant vector, so downstream select logic sees exactly one active grant line, or none. Grants are held until the owner releases its request. Optional timeout preemption prevents starvation by a requester that holds the grant indefinitely.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 16: maximum consecutive grant cycles per owner when preemption is compiled in; legal range 2..256.

Ports:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_rst, input, 1: reset, synchronous, active-high.
- i_en, input, 1: arbiter enable; 0 withdraws and blocks grants.
- i_req, input, 4: request per requester; level-sensitive, held high for as long as access is wanted.
- o_gnt, output, 4: registered one-hot grant, equal to the decode of o_gnt_idx when o_gnt_vld=1; otherwise 4'b0000.
- o_gnt_idx, output, 2: registered index of the current or most recent owner.
- o_gnt_vld, output, 1: registered; 1 while any grant is active.
- o_timeout, output, 1: registered one-cycle pulse when a grant is preempted; tied to 0 without the macro.

## Operation
- States: IDLE (no grant) and GRANT (owner = o_gnt_idx).
- Internal 2-bit pointer ptr: the search start. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first set i_req bit in that order wins.
- IDLE:
  - If i_en=1 and i_req≠0, grant the winner and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, evaluated in priority order:
  1. If i_en=0: drop the grant and go to IDLE. ptr is unchanged.
  2. If i_req[owner]=0 (release): set ptr=owner+1, then re-arbitrate on the current i_req with that new ptr.
     - If there is a winner, grant it directly with no idle gap.
     - Otherwise go to IDLE.
  3. Timeout (macro only): applies when the hold counter equals TIMEOUT_CYCLES-1 and the owner still requests.
     - If any other i_req bit is set: set ptr=owner+1, grant the winner among the others, and pulse o_timeout.
     - If no other requester exists: the owner keeps the grant and the counter restarts at 0.
  4. Otherwise hold the grant.
- Hold counter:
  - Resets to 0 on every new grant, including a handover.
  - Increments each GRANT cycle and saturates at TIMEOUT_CYCLES-1.
  - Width is ceil(log2(TIMEOUT_CYCLES)).
- Simultaneous events:
  - Release and timeout in the same cycle count as a release; o_timeout stays 0.
  - i_en=0 overrides both release and timeout.
- o_gnt, o_gnt_idx and o_gnt_vld always change together and never show two hot bits.

## Timing
- Reset values: state=IDLE, o_gnt=4'b0000, o_gnt_idx=2'd0, o_gnt_vld=0, o_timeout=0, ptr=0, counter=0. After reset, requester 0 has the highest priority.
- Reset asserted mid-grant: all outputs are at reset values on the cycle after the reset edge. An in-flight grant is lost without a timeout pulse.
- Grant latency: a request sampled at edge N is visible on o_gnt after edge N (1 cycle).
- Release latency: i_req[owner] low at edge N causes the grant to drop or hand over after edge N.
- Handover: zero idle cycles between consecutive owners.
- Timeout: the owner holds o_gnt for exactly TIMEOUT_CYCLES cycles. o_timeout is high during the first cycle of the new owner's grant.
- i_en low sampled at edge N gives o_gnt=0 after edge N.

## Configuration
- RR_ARB4_TIMEOUT_EN defined: the hold counter, preemption and o_timeout are implemented as above.
- RR_ARB4_TIMEOUT_EN undefined:
  - No counter is built and TIMEOUT_CYCLES is ignored.
  - o_timeout is constant 0.
  - An owner keeps the grant until it releases or i_en drops.

## Test plan
- Grant after reset: reset, then i_en=1 with i_req=4'b1010. One cycle later o_gnt=4'b0010, o_gnt_idx=1 and o_gnt_vld=1.
- Zero-gap handover: owner 1 drops its request while i_req=4'b1001. The next cycle gives o_gnt=4'b1000 (search starts at 2), with no zero cycle in between.
- Round-robin fairness: i_req=4'b1111, with each owner releasing after 1 grant cycle and re-requesting. Grant order is 0,1,2,3,0 with no gaps.
- Enable withdrawal: i_en dropped while o_gnt=4'b0100. The next cycle gives o_gnt=0 and o_gnt_vld=0. Restoring i_en with i_req=4'b0100 re-grants index 2.
- Timeout (macro defined, TIMEOUT_CYCLES=4), i_req=4'b0011 held:
  - o_gnt=4'b0001 for exactly 4 cycles, then o_gnt=4'b0010 with a one-cycle o_timeout pulse.
  - With i_req=4'b0001 alone, the grant persists and o_timeout stays 0.
- Mid-grant reset: i_rst pulsed during a grant to owner 3. The next cycle shows all outputs at zero. After reset deasserts, i_req=4'b1001 grants index 0.

Source files
------------

// File: rtl/rr_arb4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb4_ctrl
// Brief    : Four-requester round-robin arbiter with registered one-hot grant.
//            Optional timeout preemption via macro RR_ARB4_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb4_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_idx,
  output logic       o_gnt_vld,
  output logic       o_timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_idx;
  logic [3:0] r_gnt;
  logic       r_vld;
  logic       r_timeout;

  // Returns {found, index} of the first set bit scanning start, start+1, ...
  function automatic logic [2:0] f_search(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] pos;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      pos = start + 2'(k);
      if (req[pos]) res = {1'b1, pos};
    end
    return res;
  endfunction

  logic [2:0] w_idle_win;
  logic [2:0] w_next_win;
  logic [1:0] w_ptr_next;
  logic [3:0] w_owner_mask;

  assign w_owner_mask = 4'b0001 << r_idx;
  assign w_ptr_next   = r_idx + 2'd1;
  assign w_idle_win   = f_search(i_req, r_ptr);
  // Owner is excluded so release and preemption share one search
  assign w_next_win   = f_search(i_req & ~w_owner_mask, w_ptr_next);

`ifdef RR_ARB4_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_expired;
  assign w_expired = (r_cnt == C_CNT_MAX);
`else
  logic [8:0] w_unused_timeout;
  assign w_unused_timeout = 9'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_idx     <= 2'd0;
      r_gnt     <= 4'b0000;
      r_vld     <= 1'b0;
      r_timeout <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_en && w_idle_win[2]) begin
            r_state <= ST_GRANT;
            r_idx   <= w_idle_win[1:0];
            r_gnt   <= 4'b0001 << w_idle_win[1:0];
            r_vld   <= 1'b1;
`ifdef RR_ARB4_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (!i_en) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_vld   <= 1'b0;
          end else if (!i_req[r_idx]) begin
            r_ptr <= w_ptr_next;
            if (w_next_win[2]) begin
              r_idx <= w_next_win[1:0];
              r_gnt <= 4'b0001 << w_next_win[1:0];
`ifdef RR_ARB4_TIMEOUT_EN
              r_cnt <= '0;
`endif
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= 4'b0000;
              r_vld   <= 1'b0;
            end
          end
`ifdef RR_ARB4_TIMEOUT_EN
          else if (w_expired) begin
            r_cnt <= '0;
            if (w_next_win[2]) begin
              r_ptr     <= w_ptr_next;
              r_idx     <= w_next_win[1:0];
              r_gnt     <= 4'b0001 << w_next_win[1:0];
              r_timeout <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 4'b0000;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_idx = r_idx;
  assign o_gnt_vld = r_vld;
  assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb4_ctrl
// Brief    : Directed vector bench for rr_arb4_ctrl (timeout checks follow
//            RR_ARB4_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb4_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int n_checks;
  int n_fail;

  rr_arb4_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_req     (req),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_gnt_vld (gnt_vld),
    .o_timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [7:0] exp_v);
    logic [7:0] act;
    act = {gnt, gnt_idx, gnt_vld, timeout};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, expected gnt=%b idx=%0d vld=%b to=%b",
               name, act[7:4], act[3:2], act[1], act[0],
               exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    en  = 1'b0;
    req = 4'b0000;

    //          en    req      gnt      idx   vld   to
    vecs[0]  = '{1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'b1011, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};

    do_reset();
    check("reset_state", 8'b0000_00_0_0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].en, vecs[i].req);
      check($sformatf("vec%0d", i), {vecs[i].gnt, vecs[i].idx, vecs[i].vld, vecs[i].to});
    end

    // Reset in the middle of owner 3's grant drops everything, no pulse
    rst = 1'b1;
    step(1'b1, 4'b1111);
    check("midgrant_reset", 8'b0000_00_0_0);
    rst = 1'b0;
    step(1'b1, 4'b1001);
    check("post_reset_grant", {4'b0001, 2'd0, 1'b1, 1'b0});

    do_reset();
`ifdef RR_ARB4_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 4'b0011);
      check($sformatf("to_hold%0d", c), {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    step(1'b1, 4'b0011);
    check("to_preempt", {4'b0010, 2'd1, 1'b1, 1'b1});
    step(1'b1, 4'b0011);
    check("to_pulse_end", {4'b0010, 2'd1, 1'b1, 1'b0});
    step(1'b1, 4'b0001);
    check("to_release", {4'b0001, 2'd0, 1'b1, 1'b0});
    for (int c = 0; c < 9; c++) begin
      step(1'b1, 4'b0001);
      check($sformatf("to_alone%0d", c), {4'b0001, 2'd0, 1'b1, 1'b0});
    end
`else
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 4'b0011);
      check($sformatf("hold%0d", c), {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    step(1'b1, 4'b0010);
    check("hold_release", {4'b0010, 2'd1, 1'b1, 1'b0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
